// File: rtl/fc8_bus_arbiter_if.sv
// Bundled CPU/DMA request ports and memory-side port of the FC8 memory arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface fc8_bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        bus_owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, bus_owner,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, bus_owner,
    output mem_rdata
  );
endinterface

// File: rtl/fc8_bus_arbiter.sv
// Two-requester memory arbiter: DMA has priority, a burst guard lets a waiting CPU in
// after DMA_BURST_MAX consecutive DMA grants. Memory side registered, reads return 2 cycles after accept.
module fc8_bus_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int DMA_BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  fc8_bus_arbiter_if.slave   bus
);
  localparam int CNT_W = (DMA_BURST_MAX > 0) ? $clog2(DMA_BURST_MAX + 1) : 1;
  localparam logic [1:0] OWN_IDLE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  logic [CNT_W-1:0]  r_burst_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        r_bus_owner;
  logic [1:0]        r_rd_owner;

  logic              w_guard;
  logic              w_cpu_gnt;
  logic              w_dma_gnt;
  logic [1:0]        w_rvalid;
  logic [DATA_W-1:0] w_rdata [2];

  generate
    if (DMA_BURST_MAX > 0) begin : g_guard
      assign w_guard = (r_burst_cnt == CNT_W'(DMA_BURST_MAX));
    end else begin : g_no_guard
      assign w_guard = 1'b0;
    end
  endgenerate

  assign w_cpu_gnt = bus.cpu_req & (~bus.dma_req | w_guard);
  assign w_dma_gnt = bus.dma_req & ~(bus.cpu_req & w_guard);
  assign bus.cpu_gnt = w_cpu_gnt;
  assign bus.dma_gnt = w_dma_gnt;

  // Counts DMA wins while the CPU is kept waiting; any CPU win restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_burst_cnt <= '0;
    end else if (w_cpu_gnt) begin
      r_burst_cnt <= '0;
    end else if (w_dma_gnt && bus.cpu_req && (DMA_BURST_MAX > 0) && !w_guard) begin
      r_burst_cnt <= r_burst_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_bus_owner <= OWN_IDLE;
    end else if (w_cpu_gnt) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= bus.cpu_we;
      r_mem_addr  <= bus.cpu_addr;
      r_mem_wdata <= bus.cpu_wdata;
      r_bus_owner <= OWN_CPU;
    end else if (w_dma_gnt) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= bus.dma_we;
      r_mem_addr  <= bus.dma_addr;
      r_mem_wdata <= bus.dma_wdata;
      r_bus_owner <= OWN_DMA;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_bus_owner <= OWN_IDLE;
    end
  end

  // Second read-tag stage; the first stage is the access currently on mem_*.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_owner <= OWN_IDLE;
    end else begin
      r_rd_owner <= (r_mem_en && !r_mem_we) ? r_bus_owner : OWN_IDLE;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      localparam logic [1:0] OWN = (gi == 0) ? OWN_CPU : OWN_DMA;
      assign w_rvalid[gi] = (r_rd_owner == OWN);
      assign w_rdata[gi]  = w_rvalid[gi] ? bus.mem_rdata : '0;
    end
  endgenerate

  assign bus.cpu_rvalid = w_rvalid[0];
  assign bus.cpu_rdata  = w_rdata[0];
  assign bus.dma_rvalid = w_rvalid[1];
  assign bus.dma_rdata  = w_rdata[1];

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.bus_owner = r_bus_owner;
endmodule

// File: tb/tb_fc8_bus_arbiter.sv
// Self-checking bench for fc8_bus_arbiter: transaction-level model plus directed literal checks.
// A second instance with DMA_BURST_MAX=0 shares the stimulus to exercise strict priority.
module tb_fc8_bus_arbiter;
  localparam int BMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic [7:0]  ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  fc8_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus4 ();
  fc8_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus0 ();

  fc8_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .DMA_BURST_MAX(BMAX)) dut (
    .clk(clk), .rst(rst), .bus(bus4));
  fc8_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .DMA_BURST_MAX(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));

  assign bus4.cpu_req = cpu_req;   assign bus0.cpu_req = cpu_req;
  assign bus4.cpu_we = cpu_we;     assign bus0.cpu_we = cpu_we;
  assign bus4.cpu_addr = cpu_addr; assign bus0.cpu_addr = cpu_addr;
  assign bus4.cpu_wdata = cpu_wdata; assign bus0.cpu_wdata = cpu_wdata;
  assign bus4.dma_req = dma_req;   assign bus0.dma_req = dma_req;
  assign bus4.dma_we = dma_we;     assign bus0.dma_we = dma_we;
  assign bus4.dma_addr = dma_addr; assign bus0.dma_addr = dma_addr;
  assign bus4.dma_wdata = dma_wdata; assign bus0.dma_wdata = dma_wdata;
  assign bus4.mem_rdata = ram_rdata;
  assign bus0.mem_rdata = 8'h00;

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  // Memory stub behind the arbiter: synchronous read, one-cycle latency.
  logic [7:0] ram [int];
  always @(posedge clk) begin
    if (bus4.mem_en && bus4.mem_we) ram[int'(bus4.mem_addr)] = bus4.mem_wdata;
    if (bus4.mem_en && !bus4.mem_we)
      ram_rdata <= ram.exists(int'(bus4.mem_addr)) ? ram[int'(bus4.mem_addr)] : dflt(bus4.mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cyc=%0d %s got=%0h exp=%0h", cyc, name, act, exp);
    end
  endtask

  // Transaction-level model: expected memory contents, pending reads, waiting-CPU streak.
  typedef struct { int due; logic [1:0] owner; logic [7:0] data; } rd_t;
  rd_t        rq[$];
  logic [7:0] model_mem [int];
  int         m_streak;
  logic       m_en, m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic [1:0]  m_owner;

  function automatic logic [7:0] mread(input logic [15:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : dflt(a);
  endfunction

  always @(negedge clk) begin
    logic ecg, edg, evc, evd;
    logic [7:0] ed;
    cyc++;
    if (rst) begin
      m_streak = 0; m_en = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_owner = 0;
      rq.delete();
    end
    ecg = cpu_req && (!dma_req || (m_streak == BMAX));
    edg = dma_req && !ecg;
    chk("cpu_gnt", bus4.cpu_gnt, ecg);
    chk("dma_gnt", bus4.dma_gnt, edg);
    chk("mem_en", bus4.mem_en, m_en);
    chk("mem_we", bus4.mem_we, m_we);
    chk("mem_addr", bus4.mem_addr, m_addr);
    chk("mem_wdata", bus4.mem_wdata, m_wdata);
    chk("bus_owner", bus4.bus_owner, m_owner);
    evc = 0; evd = 0; ed = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      evc = (rq[0].owner == 2'b01);
      evd = (rq[0].owner == 2'b10);
      ed  = rq[0].data;
      void'(rq.pop_front());
    end
    chk("cpu_rvalid", bus4.cpu_rvalid, evc);
    chk("dma_rvalid", bus4.dma_rvalid, evd);
    chk("cpu_rdata", bus4.cpu_rdata, evc ? ed : 8'h00);
    chk("dma_rdata", bus4.dma_rdata, evd ? ed : 8'h00);
    chk("strict_gnt_excl", {bus0.cpu_gnt, bus0.dma_gnt},
        {cpu_req && !dma_req, dma_req});
    if (!rst) begin
      if (ecg || edg) begin
        m_en    = 1'b1;
        m_we    = ecg ? cpu_we : dma_we;
        m_addr  = ecg ? cpu_addr : dma_addr;
        m_wdata = ecg ? cpu_wdata : dma_wdata;
        m_owner = ecg ? 2'b01 : 2'b10;
        if (m_we) model_mem[int'(m_addr)] = m_wdata;
        else rq.push_back('{cyc + 2, m_owner, mread(m_addr)});
      end else begin
        m_en = 0; m_we = 0; m_owner = 0;
      end
      if (ecg) m_streak = 0;
      else if (edg && cpu_req && m_streak < BMAX) m_streak++;
    end
  end

  task automatic drive(input logic r,
                       input logic creq, input logic cwe, input logic [15:0] ca, input logic [7:0] cd,
                       input logic dreq, input logic dwe, input logic [15:0] da, input logic [7:0] dd);
    @(posedge clk);
    #1;
    rst = r;
    cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dreq; dma_we = dwe; dma_addr = da; dma_wdata = dd;
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    drive(r, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
  endtask

  initial begin
    string exp_seq;
    byte   got;
    int    n0d, n0c;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    ram[32'h8000] = 8'hA9; model_mem[32'h8000] = 8'hA9;
    ram[32'h1000] = 8'h3C; model_mem[32'h1000] = 8'h3C;
    ram[32'h2000] = 8'hC3; model_mem[32'h2000] = 8'hC3;

    idle(1); idle(1);
    chk("lit_rst_mem_en", bus4.mem_en, 1'b0);
    chk("lit_rst_owner", bus4.bus_owner, 2'b00);
    idle(0);

    drive(0, 1, 0, 16'h8000, 8'h00, 0, 0, 16'h0, 8'h0);
    chk("lit_rd_cpu_gnt", bus4.cpu_gnt, 1'b1);
    idle(0);
    chk("lit_rd_mem_en", bus4.mem_en, 1'b1);
    chk("lit_rd_mem_addr", bus4.mem_addr, 16'h8000);
    chk("lit_rd_owner", bus4.bus_owner, 2'b01);
    idle(0);
    chk("lit_rd_cpu_rvalid", bus4.cpu_rvalid, 1'b1);
    chk("lit_rd_cpu_rdata", bus4.cpu_rdata, 8'hA9);
    chk("lit_rd_dma_rvalid", bus4.dma_rvalid, 1'b0);
    $display("txn cpu_read addr=8000 data=%0h", bus4.cpu_rdata);

    drive(0, 1, 1, 16'h0200, 8'h5A, 0, 0, 16'h0, 8'h0);
    idle(0);
    chk("lit_wr_mem_we", bus4.mem_we, 1'b1);
    chk("lit_wr_mem_addr", bus4.mem_addr, 16'h0200);
    chk("lit_wr_mem_wdata", bus4.mem_wdata, 8'h5A);
    idle(0);
    chk("lit_wr_no_rvalid", bus4.cpu_rvalid, 1'b0);
    $display("txn cpu_write addr=0200 data=5a");

    drive(0, 0, 0, 16'h0, 8'h0, 1, 0, 16'h1000, 8'h0);
    drive(0, 1, 0, 16'h2000, 8'h0, 0, 0, 16'h0, 8'h0);
    idle(0);
    chk("lit_il_dma_rvalid", bus4.dma_rvalid, 1'b1);
    chk("lit_il_dma_rdata", bus4.dma_rdata, 8'h3C);
    chk("lit_il_cpu_rvalid0", bus4.cpu_rvalid, 1'b0);
    idle(0);
    chk("lit_il_cpu_rvalid", bus4.cpu_rvalid, 1'b1);
    chk("lit_il_cpu_rdata", bus4.cpu_rdata, 8'hC3);
    chk("lit_il_dma_rvalid1", bus4.dma_rvalid, 1'b0);
    $display("txn interleaved dma=1000 cpu=2000");

    exp_seq = "DDDDCDDDDC";
    n0d = 0; n0c = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 16'h3000, 8'h0, 1, i[0], 16'h1100 + 16'(i), 8'h40 + 8'(i));
      got = bus4.dma_gnt ? "D" : (bus4.cpu_gnt ? "C" : "-");
      chk("lit_seq", got, exp_seq.getc(i));
      if (i > 0 && exp_seq.getc(i - 1) == "C") chk("lit_cnt_after_c", dut.r_burst_cnt, 0);
      if (bus0.dma_gnt) n0d++;
      if (bus0.cpu_gnt) n0c++;
      $display("txn contention cycle=%0d grant=%c", i, got);
    end
    idle(0);
    chk("lit_cnt_after_c", dut.r_burst_cnt, 0);
    chk("lit_strict_dma", n0d, 10);
    chk("lit_strict_cpu", n0c, 0);
    idle(0); idle(0);

    drive(0, 1, 0, 16'h4000, 8'h0, 1, 1, 16'h1200, 8'h77);
    idle(0);
    chk("lit_drop_owner", bus4.bus_owner, 2'b10);
    idle(0);
    chk("lit_drop_mem_en", bus4.mem_en, 1'b0);
    $display("txn cpu_req_dropped");

    drive(0, 1, 0, 16'h8000, 8'h0, 0, 0, 16'h0, 8'h0);
    idle(1);
    chk("lit_rst_mid_en", bus4.mem_en, 1'b0);
    chk("lit_rst_mid_owner", bus4.bus_owner, 2'b00);
    idle(0);
    chk("lit_rst_mid_rvalid", bus4.cpu_rvalid, 1'b0);
    drive(0, 1, 0, 16'h0200, 8'h0, 0, 0, 16'h0, 8'h0);
    chk("lit_post_rst_gnt", bus4.cpu_gnt, 1'b1);
    idle(0); idle(0);
    chk("lit_post_rst_rvalid", bus4.cpu_rvalid, 1'b1);
    chk("lit_post_rst_rdata", bus4.cpu_rdata, 8'h5A);
    $display("txn reset_mid_read then cpu_read addr=0200 data=%0h", bus4.cpu_rdata);
    idle(0); idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
